// File: rtl/core_pkg.sv
// Shared core package: default widths and register-file controller state encodings.
// Exports:
//   XLEN_DEF, NREGS_DEF  default data width and register count
//   rf_state_t           state type of the register-file clear/run controller
//   RF_CLEAR, RF_RUN     state constants (clear engine active / normal operation)
package core_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 16;

  typedef logic [0:0] rf_state_t;

  localparam rf_state_t RF_CLEAR = 1'b0;
  localparam rf_state_t RF_RUN   = 1'b1;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle of the scoreboarded register file.
// master: pipeline side (drives writeback, read indices, issue; sees read data and status).
// slave : register file side.
//   wb_en, wb_mreg, wb_wn, mem_data, alu_result  writeback request and its two data sources
//   rn1, rn2 / rd1, rd2                          read indices / read data
//   iss_en, iss_wn                               issue of an instruction with a destination
//   pend1, pend2                                 scoreboard status of rn1 / rn2
//   dbg_rd                                       debug tap contents
//   ready                                        low while the clear engine runs
interface regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 4
);

  logic            wb_en;
  logic            wb_mreg;
  logic [AW-1:0]   wb_wn;
  logic [XLEN-1:0] mem_data;
  logic [XLEN-1:0] alu_result;
  logic [AW-1:0]   rn1;
  logic [AW-1:0]   rn2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            iss_en;
  logic [AW-1:0]   iss_wn;
  logic            pend1;
  logic            pend2;
  logic [XLEN-1:0] dbg_rd;
  logic            ready;

  modport master (
    output wb_en, wb_mreg, wb_wn, mem_data, alu_result, rn1, rn2, iss_en, iss_wn,
    input  rd1, rd2, pend1, pend2, dbg_rd, ready
  );

  modport slave (
    input  wb_en, wb_mreg, wb_wn, mem_data, alu_result, rn1, rn2, iss_en, iss_wn,
    output rd1, rd2, pend1, pend2, dbg_rd, ready
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears every bit)
//   set_en, set_idx   mark a register as having an outstanding write
//   clr_en, clr_idx   writeback completing for a register
//   rn1, rn2          lookup indices
//   pend1, pend2      pending status; a write completing this cycle already counts as done
module rf_scoreboard #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rn1,
  input  logic [AW-1:0] rn2,
  output logic          pend1,
  output logic          pend2
);

  logic [NREGS-1:0] sb_q, sb_d;

  // Set is applied last so a newer issue to the same register stays outstanding.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_idx] = 1'b0;
    if (set_en) sb_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  always_comb begin
    pend1 = sb_q[rn1] & ~(clr_en & (clr_idx == rn1));
    pend2 = sb_q[rn2] & ~(clr_en & (clr_idx == rn2));
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with writeback mux, write-to-read bypass, pending-write
// scoreboard, post-reset clear engine and a debug tap on one register.
// Ports:
//   clk   clock, all state updates on posedge
//   rst   asynchronous active-high reset; restarts the clear engine
//   bus   regfile_sb_if.slave: writeback, reads, issue, pending, debug tap, ready
module regfile_sb
  import core_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned DBG_IDX = 4
) (
  input  logic      clk,
  input  logic      rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned   AW     = $clog2(NREGS);
  localparam logic          ZeroR0 = (ZERO_R0 != 0);
  localparam logic [AW-1:0] DbgSel = AW'(DBG_IDX);
  localparam logic [AW-1:0] LastIx = AW'(NREGS - 1);

  rf_state_t       state_q;
  logic [AW-1:0]   clr_idx_q;
  logic [XLEN-1:0] mem [NREGS];
  logic            ready;
  logic            we;
  logic            set_en;
  logic [XLEN-1:0] wd;

  // Clear engine: one register zeroed per cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else if (state_q == RF_CLEAR) begin
      clr_idx_q <= clr_idx_q + 1'b1;
      if (clr_idx_q == LastIx) state_q <= RF_RUN;
    end
  end

  always_comb begin
    ready  = (state_q == RF_RUN);
    wd     = bus.wb_mreg ? bus.mem_data : bus.alu_result;
    we     = ready & bus.wb_en & ~(ZeroR0 & (bus.wb_wn == '0));
    set_en = ready & bus.iss_en & ~(ZeroR0 & (bus.iss_wn == '0));
  end

  // Storage has no reset; the clear engine provides the zero state.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) mem[clr_idx_q] <= '0;
    else if (we)             mem[bus.wb_wn] <= wd;
  end

  always_comb begin
    bus.ready  = ready;
    bus.rd1    = '0;
    bus.rd2    = '0;
    bus.dbg_rd = '0;
    if (ready) begin
      if (!(ZeroR0 && (bus.rn1 == '0))) begin
        bus.rd1 = (we && (bus.wb_wn == bus.rn1)) ? wd : mem[bus.rn1];
      end
      if (!(ZeroR0 && (bus.rn2 == '0))) begin
        bus.rd2 = (we && (bus.wb_wn == bus.rn2)) ? wd : mem[bus.rn2];
      end
      bus.dbg_rd = mem[DbgSel];
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_idx (bus.iss_wn),
    .clr_en  (we),
    .clr_idx (bus.wb_wn),
    .rn1     (bus.rn1),
    .rn2     (bus.rn2),
    .pend1   (bus.pend1),
    .pend2   (bus.pend2)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic,
// all compared against a register-level behavioural model of the register file.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DBG   = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .ZERO_R0 (1),
    .DBG_IDX (DBG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model
  logic [XLEN-1:0] m_reg [NREGS];
  logic            m_sb  [NREGS];
  logic            m_ready;
  int              m_cnt;

  function automatic logic [XLEN-1:0] m_wd();
    return bus.wb_mreg ? bus.mem_data : bus.alu_result;
  endfunction

  function automatic logic m_we();
    return m_ready && bus.wb_en && (int'(bus.wb_wn) != 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] rn);
    if (!m_ready || int'(rn) == 0) return '0;
    if (m_we() && bus.wb_wn == rn) return m_wd();
    return m_reg[rn];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] rn);
    return m_sb[rn] && !(m_we() && bus.wb_wn == rn);
  endfunction

  function automatic logic [XLEN-1:0] exp_dbg();
    return m_ready ? m_reg[DBG] : '0;
  endfunction

  task automatic model_edge();
    if (rst) return;
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NREGS) begin
        m_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
      end
    end else begin
      if (m_we()) begin
        m_reg[bus.wb_wn] = m_wd();
        m_sb[bus.wb_wn]  = 1'b0;
      end
      if (bus.iss_en && int'(bus.iss_wn) != 0) m_sb[bus.iss_wn] = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < NREGS; i++) m_sb[i] = 1'b0;
  endtask

  // Inputs change just after negedge; the model samples them at the posedge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wb_en = 0; bus.wb_mreg = 0; bus.wb_wn = '0; bus.mem_data = '0; bus.alu_result = '0;
    bus.rn1 = '0; bus.rn2 = '0; bus.iss_en = 0; bus.iss_wn = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.pend1 !== 1'b0 || bus.pend2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: ready=%b pend1=%b pend2=%b required 0 0 0",
               bus.ready, bus.pend1, bus.pend2);
    end
    repeat (3) cycle();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      bus.rn1 = AW'($urandom_range(0, NREGS - 1));
      bus.rn2 = AW'($urandom_range(0, NREGS - 1));
      cycle();
      #1;
      checks++;
      if (bus.ready !== (k >= NREGS)) begin
        errors++;
        $display("FAIL clear_ready cycle %0d: got %b required %b", k, bus.ready, k >= NREGS);
      end
      checks++;
      if (bus.rd1 !== '0 || bus.rd2 !== '0 || bus.dbg_rd !== '0) begin
        errors++;
        $display("FAIL clear_reads cycle %0d: rd1=%h rd2=%h dbg=%h required 0",
                 k, bus.rd1, bus.rd2, bus.dbg_rd);
      end
    end
  endtask

  task automatic test_write_bypass();
    bus.wb_en = 1; bus.wb_mreg = 0; bus.wb_wn = 4'd5; bus.alu_result = 32'h906AF;
    bus.mem_data = 32'h1111_2222; bus.rn1 = 4'd5;
    #1;
    checks++;
    if (bus.rd1 !== 32'h906AF) begin
      errors++; $display("FAIL bypass_alu: got %h required %h", bus.rd1, 32'h906AF);
    end
    cycle();
    bus.wb_en = 0;
    #1;
    checks++;
    if (bus.rd1 !== 32'h906AF) begin
      errors++; $display("FAIL stored_alu: got %h required %h", bus.rd1, 32'h906AF);
    end
    bus.wb_en = 1; bus.wb_mreg = 1; bus.mem_data = 32'hDEADBEEF; bus.alu_result = 32'h1234_5678;
    #1;
    checks++;
    if (bus.rd1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_mem: got %h required %h", bus.rd1, 32'hDEADBEEF);
    end
    cycle();
    bus.wb_en = 0;
    #1;
    checks++;
    if (bus.rd1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL stored_mem: got %h required %h", bus.rd1, 32'hDEADBEEF);
    end
  endtask

  task automatic test_r0();
    bus.wb_en = 1; bus.wb_mreg = 0; bus.wb_wn = '0; bus.alu_result = 32'hFFFFFFFF; bus.rn1 = '0;
    #1;
    checks++;
    if (bus.rd1 !== '0) begin
      errors++; $display("FAIL r0_bypass: got %h required 0", bus.rd1);
    end
    cycle();
    bus.wb_en = 0;
    bus.iss_en = 1; bus.iss_wn = '0;
    #1;
    checks++;
    if (bus.rd1 !== '0) begin
      errors++; $display("FAIL r0_stored: got %h required 0", bus.rd1);
    end
    cycle();
    bus.iss_en = 0;
    #1;
    checks++;
    if (bus.pend1 !== 1'b0) begin
      errors++; $display("FAIL r0_pend: got %b required 0", bus.pend1);
    end
  endtask

  task automatic test_scoreboard();
    bus.iss_en = 1; bus.iss_wn = 4'd7; bus.rn2 = 4'd7;
    #1;
    checks++;
    if (bus.pend2 !== 1'b0) begin
      errors++; $display("FAIL sb_before_issue: got %b required 0", bus.pend2);
    end
    cycle();
    bus.iss_en = 0;
    #1;
    checks++;
    if (bus.pend2 !== 1'b1) begin
      errors++; $display("FAIL sb_after_issue: got %b required 1", bus.pend2);
    end
    bus.wb_en = 1; bus.wb_wn = 4'd7; bus.wb_mreg = 0; bus.alu_result = 32'h77;
    #1;
    checks++;
    if (bus.pend2 !== 1'b0) begin
      errors++; $display("FAIL sb_wb_same_cycle: got %b required 0", bus.pend2);
    end
    cycle();
    bus.wb_en = 0;
    #1;
    checks++;
    if (bus.pend2 !== 1'b0) begin
      errors++; $display("FAIL sb_wb_after: got %b required 0", bus.pend2);
    end
    bus.iss_en = 1;
    cycle();
    bus.wb_en = 1; bus.alu_result = 32'h78;
    cycle();
    bus.iss_en = 0; bus.wb_en = 0;
    #1;
    checks++;
    if (bus.pend2 !== 1'b1) begin
      errors++; $display("FAIL sb_set_wins: got %b required 1", bus.pend2);
    end
    bus.wb_en = 1;
    cycle();
    bus.wb_en = 0;
  endtask

  task automatic test_debug();
    bus.wb_en = 1; bus.wb_mreg = 0; bus.wb_wn = 4'd4; bus.alu_result = 32'h5;
    #1;
    checks++;
    if (bus.dbg_rd !== exp_dbg() || bus.dbg_rd === 32'h5) begin
      errors++; $display("FAIL dbg_before_edge: got %h required %h", bus.dbg_rd, exp_dbg());
    end
    cycle();
    bus.wb_en = 0;
    #1;
    checks++;
    if (bus.dbg_rd !== 32'h5) begin
      errors++; $display("FAIL dbg_after_edge: got %h required %h", bus.dbg_rd, 32'h5);
    end
  endtask

  task automatic test_mid_reset();
    int waited;
    bus.wb_en = 1; bus.wb_mreg = 0; bus.wb_wn = 4'd3; bus.alu_result = 32'h430A1;
    bus.iss_en = 1; bus.iss_wn = 4'd3;
    cycle();
    bus.wb_en = 0; bus.iss_en = 0; bus.rn1 = 4'd3;
    #1;
    checks++;
    if (bus.pend1 !== 1'b1 || bus.rd1 !== 32'h430A1) begin
      errors++;
      $display("FAIL midrst_setup: pend1=%b rd1=%h required 1 %h", bus.pend1, bus.rd1, 32'h430A1);
    end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.pend1 !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: pend1=%b ready=%b required 0 0", bus.pend1, bus.ready);
    end
    bus.wb_en = 1; bus.wb_wn = 4'd3; bus.alu_result = 32'hFFFF; bus.iss_en = 1; bus.iss_wn = 4'd6;
    cycle();
    cycle();
    rst = 1'b0;
    waited = 0;
    while (bus.ready !== 1'b1 && waited < 40) begin
      cycle();
      waited++;
    end
    checks++;
    if (bus.ready !== 1'b1 || waited != NREGS) begin
      errors++;
      $display("FAIL midrst_clear_len: ready=%b after %0d cycles required 1 after %0d",
               bus.ready, waited, NREGS);
    end
    bus.wb_en = 0; bus.iss_en = 0; bus.rn1 = 4'd3; bus.rn2 = 4'd6;
    #1;
    checks++;
    if (bus.rd1 !== '0 || bus.pend2 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after_clear: rd1=%h pend2=%b required 0 0", bus.rd1, bus.pend2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.wb_en      = ($urandom_range(0, 2) != 0);
      bus.wb_mreg    = 1'($urandom);
      bus.wb_wn      = AW'($urandom);
      bus.mem_data   = $urandom;
      bus.alu_result = $urandom;
      bus.iss_en     = ($urandom_range(0, 2) == 0);
      bus.iss_wn     = AW'($urandom);
      bus.rn1        = ($urandom_range(0, 3) == 0) ? bus.wb_wn : AW'($urandom);
      bus.rn2        = ($urandom_range(0, 3) == 0) ? bus.wb_wn : AW'($urandom);
      #1;
      checks++;
      if (bus.rd1 !== exp_rd(bus.rn1) || bus.rd2 !== exp_rd(bus.rn2)) begin
        errors++;
        $display("FAIL rand_rd #%0d: rd1=%h rd2=%h required %h %h",
                 n, bus.rd1, bus.rd2, exp_rd(bus.rn1), exp_rd(bus.rn2));
      end
      checks++;
      if (bus.pend1 !== exp_pend(bus.rn1) || bus.pend2 !== exp_pend(bus.rn2)) begin
        errors++;
        $display("FAIL rand_pend #%0d: pend1=%b pend2=%b required %b %b",
                 n, bus.pend1, bus.pend2, exp_pend(bus.rn1), exp_pend(bus.rn2));
      end
      checks++;
      if (bus.dbg_rd !== exp_dbg() || bus.ready !== m_ready) begin
        errors++;
        $display("FAIL rand_dbg #%0d: dbg=%h ready=%b required %h %b",
                 n, bus.dbg_rd, bus.ready, exp_dbg(), m_ready);
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    @(negedge clk);
    test_reset();
    test_write_bypass();
    test_r0();
    test_scoreboard();
    test_debug();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
